alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one 8-bit combinational ALU (operands A, B, 4-bit select S, result F) between NREQ independent requesters. Round-robin arbitration picks one request at a time, registers its operands, drives the ALU, captures the result with a derived zero flag, and returns it on a single valid/ready response channel tagged with the requester ID. It sits between the ALU and its client units; it is the only driver of the ALU inputs.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(NREQ), width of the requester ID
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  request accepted this cycle, one-hot or zero
- req_a  in  8*NREQ  operand A; requester i uses bits [8i+7:8i]
- req_b  in  8*NREQ  operand B, same packing
- req_op  in  4*NREQ  ALU select; requester i uses bits [4i+3:4i]
- alu_a  out  8  to ALU input A
- alu_b  out  8  to ALU input B
- alu_s  out  4  to ALU select
- alu_f  in  8  ALU result, combinational from alu_a/alu_b/alu_s
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_data  out  8  captured ALU result
- rsp_zero  out  1  rsp_data == 8'h00
- rsp_err  out  1  opcode was unassigned (4'b1100..4'b1111)
- rsp_id  out  IDW  index of the requester that issued this result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any req_valid, grant g = first index with req_valid set, scanning from rr_ptr upward, wrapping at NREQ. req_ready[g]=1 combinationally that cycle; all other req_ready=0. At the clock edge latch req_a/req_b/req_op slice g into alu_a/alu_b/alu_s, g into rsp_id, set rr_ptr = (g+1) mod NREQ, go to EXEC. No valid: stay in IDLE, req_ready all 0.
- EXEC: alu_a/alu_b/alu_s held. At the clock edge capture rsp_data = alu_f, rsp_zero = (alu_f == 0), rsp_err = (alu_s[3:2] == 2'b11); go to RESP.
- RESP: rsp_valid=1; rsp_data/rsp_zero/rsp_err/rsp_id stable until handshake. On rsp_valid & rsp_ready: go to IDLE, rsp_valid deasserts next cycle.
- req_ready is 0 in EXEC and RESP; requesters must hold req_valid and operands until their req_ready pulse.
- alu_a/alu_b/alu_s retain the last operands outside EXEC (no forced zero).
- Unassigned opcodes are still issued; the ALU returns 8'h00, so rsp_data=0, rsp_zero=1, rsp_err=1.
- Arithmetic is the ALU's own modulo-256; the block adds no width extension or overflow detection.
- Reset values: state IDLE, rr_ptr 0, req_ready 0, alu_a 0, alu_b 0, alu_s 0, rsp_valid 0, rsp_data 0, rsp_zero 0, rsp_err 0, rsp_id 0, busy 0.
- Reset mid-operation: in-flight request discarded, no response issued; requester must re-request.

## Timing
- Accept at edge T (req_valid & req_ready) -> ALU driven in cycle T+1 -> rsp_valid high from cycle T+2.
- Minimum issue interval 3 cycles (accept, exec, respond with rsp_ready=1); back-pressure on rsp_ready extends RESP indefinitely.
- Next grant can occur in the cycle right after the response handshake.
- rsp_* outputs and alu_* outputs are registered; req_ready is the only combinational output (from req_valid, rr_ptr, state).
- With all requesters valid continuously, grants rotate 0,1,...,NREQ-1,0 after reset.

## Test plan
- Single request: requester 2 sends A=8'h05, B=8'h03, op=4'b0010 -> req_ready[2] one cycle, rsp_valid 2 cycles later, rsp_data=8'h08, rsp_zero=0, rsp_err=0, rsp_id=2.
- Round-robin fairness: all four requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1, one response every 3 cycles, IDs in the same order.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and all rsp fields stable, req_ready stays 0, no new grant until the handshake.
- Wrap and zero: A=8'hFF, op=4'b0001 -> rsp_data=8'h00, rsp_zero=1; A=8'h00, op=4'b0100 -> rsp_data=8'hFF, rsp_zero=0.
- Unassigned opcode: op=4'b1110 -> rsp_data=8'h00, rsp_zero=1, rsp_err=1.
- Reset mid-operation: assert rst during EXEC -> all outputs return to reset values asynchronously, no rsp_valid; after release, requester 0 has highest priority.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one external 8-bit combinational ALU
// among NREQ requesters and returns each result on a tagged valid/ready channel.
module alu_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    input  logic [4*NREQ-1:0]    req_op,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [3:0]           alu_s,
    input  logic [7:0]           alu_f,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic                 rsp_zero,
    output logic                 rsp_err,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    localparam int unsigned DW  = 8;
    localparam int unsigned OPW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    grant;
    logic [IDW-1:0]    idx;
    logic              found;
    logic              accept;

    logic [DW-1:0]     a_arr  [NREQ];
    logic [DW-1:0]     b_arr  [NREQ];
    logic [OPW-1:0]    op_arr [NREQ];

    // Unpack the flat per-requester operand buses
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[DW*i +: DW];
        assign b_arr[i]  = req_b[DW*i +: DW];
        assign op_arr[i] = req_op[OPW*i +: OPW];
    end

    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return IDW'(s % NREQ);
    endfunction

    // First valid requester at or after rr_ptr, wrapping at NREQ
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = wrap_idx(rr_ptr, i);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign accept = (state == IDLE) && found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status flags registered from the next state so they track it exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            busy      <= (state_next != IDLE);
            rsp_valid <= (state_next == RESP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_s    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                alu_a  <= a_arr[grant];
                alu_b  <= b_arr[grant];
                alu_s  <= op_arr[grant];
                rsp_id <= grant;
                rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
            end
            if (state == EXEC) begin
                rsp_data <= alu_f;
                rsp_zero <= (alu_f == '0);
                rsp_err  <= (alu_s[3:2] == 2'b11);
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU on the alu_* port.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [15:0] req_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_s;
    logic [7:0]  alu_f;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_zero;
    logic        rsp_err;
    logic [1:0]  rsp_id;
    logic        busy;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_f(alu_f),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Client-side ALU: 0001 inc, 0010 add, 0011 sub, 0100 dec, 11xx returns zero
    always_comb begin
        case (alu_s)
            4'b0000: alu_f = alu_a;
            4'b0001: alu_f = alu_a + 8'd1;
            4'b0010: alu_f = alu_a + alu_b;
            4'b0011: alu_f = alu_a - alu_b;
            4'b0100: alu_f = alu_a - 8'd1;
            4'b0101: alu_f = alu_a & alu_b;
            4'b0110: alu_f = alu_a | alu_b;
            4'b0111: alu_f = alu_a ^ alu_b;
            4'b1000: alu_f = ~alu_a;
            4'b1001: alu_f = alu_a << 1;
            4'b1010: alu_f = alu_a >> 1;
            4'b1011: alu_f = alu_b;
            default: alu_f = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op);
        req_a[8*id +: 8]  = a;
        req_b[8*id +: 8]  = b;
        req_op[4*id +: 4] = op;
    endtask

    // One complete transaction from an idle arbiter with rsp_ready held high
    task automatic txn(input string tag, input int id, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] op,
                       input logic [7:0] exp_data, input logic exp_zero,
                       input logic exp_err);
        set_req(id, a, b, op);
        req_valid[id] = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
        step();
        req_valid[id] = 1'b0;
        step();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"},  32'(rsp_data),  32'(exp_data));
        chk({tag, "_zero"},  32'(rsp_zero),  32'(exp_zero));
        chk({tag, "_err"},   32'(rsp_err),   32'(exp_err));
        chk({tag, "_id"},    32'(rsp_id),    32'(id));
        step();
    endtask

    initial begin
        logic [1:0] rr_ids  [6];
        logic [7:0] rr_data [6];
        rr_ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rr_data = '{8'h02, 8'h12, 8'h22, 8'h32, 8'h02, 8'h12};

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
        rsp_ready = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a),     32'd0);
        chk("rst_data",  32'(rsp_data),  32'd0);
        chk("rst_id",    32'(rsp_id),    32'd0);
        rst = 1'b0;
        step();

        // Round robin: all valid, A=0x10*i+1, B=1, add
        for (int i = 0; i < 4; i++) set_req(i, 8'(16 * i + 1), 8'h01, 4'b0010);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(4'b0001 << rr_ids[k]));
            step();
            chk("rr_exec_ready", 32'(req_ready), 32'd0);
            step();
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_id",    32'(rsp_id),    32'(rr_ids[k]));
            chk("rr_data",  32'(rsp_data),  32'(rr_data[k]));
            step();
        end
        req_valid = '0;
        chk("rr_idle_busy", 32'(busy), 32'd0);

        // Single request from requester 2: 5 + 3
        set_req(2, 8'h05, 8'h03, 4'b0010);
        req_valid[2] = 1'b1;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid[2] = 1'b0;
        chk("single_busy",  32'(busy),      32'd1);
        chk("single_alu_a", 32'(alu_a),     32'h05);
        chk("single_alu_s", 32'(alu_s),     32'h2);
        chk("single_nvld",  32'(rsp_valid), 32'd0);
        step();
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_data",  32'(rsp_data),  32'h08);
        chk("single_zero",  32'(rsp_zero),  32'd0);
        chk("single_err",   32'(rsp_err),   32'd0);
        chk("single_id",    32'(rsp_id),    32'd2);
        step();
        chk("single_done",  32'(rsp_valid), 32'd0);

        // Back-pressure: requester 1 computes 0x20-0x07, requester 3 waits
        rsp_ready = 1'b0;
        set_req(1, 8'h20, 8'h07, 4'b0011);
        req_valid = 4'b0010;
        #1;
        chk("bp_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b1000;
        set_req(3, 8'hFF, 8'h00, 4'b0001);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data",  32'(rsp_data),  32'h19);
            chk("bp_id",    32'(rsp_id),    32'd1);
            chk("bp_ready0", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release", 32'(rsp_valid), 32'd0);
        req_valid = '0;

        // Wrap to zero via requester 3, then underflow, then unassigned opcode
        txn("wrap_inc", 3, 8'hFF, 8'h00, 4'b0001, 8'h00, 1'b1, 1'b0);
        txn("wrap_dec", 0, 8'h00, 8'h00, 4'b0100, 8'hFF, 1'b0, 1'b0);
        txn("unassign", 1, 8'h55, 8'h0F, 4'b1110, 8'h00, 1'b1, 1'b1);

        // Reset during EXEC drops the request and restores priority to requester 0
        set_req(3, 8'h11, 8'h22, 4'b0010);
        req_valid = 4'b1000;
        #1;
        chk("mid_ready", 32'(req_ready), 32'b1000);
        step();
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a),     32'd0);
        chk("mid_rst_id",    32'(rsp_id),    32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        step();
        chk("mid_hold_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("mid_prio0", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
